miner_job_sequencer: RTL and testbench

Synthesizable, parametrised job driver for the nonce-search miner. It replaces hand-sequenced header/target stimulus with a queue of jobs and sequences each one onto the miner: load, pulse reset, run, and collect the result. Each outcome is captured, with a watchdog timeout and a job id, into a held result register. It sits between a host or test harness and the miner core, and serves both as an on-chip driver and as the bench's stimulus engine.

---
 rtl/miner_job_sequencer_pkg.sv | 21 ++
 rtl/miner_job_sequencer_if.sv | 33 +++
 rtl/miner_job_sequencer_fifo.sv | 44 ++++
 rtl/miner_job_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_miner_job_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/miner_job_sequencer_pkg.sv
// Shared definitions for the miner job sequencer.
//   - ID_W / CNT_W : job id width and jobs_done counter width
//   - state_t      : sequencer FSM state encoding (IDLE, RST, RUN, RES)
//   - entry_width  : width of one job FIFO entry {data, target, id}
package miner_pkg;

  localparam int unsigned ID_W  = 8;
  localparam int unsigned CNT_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RST  = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t RES  = 2'd3;

  function automatic int unsigned entry_width(input int unsigned bytes,
                                              input int unsigned target_w);
    return bytes * 8 + target_w + ID_W;
  endfunction

endpackage

// File: rtl/miner_job_sequencer_if.sv
// Job-submission and result handshake bundle between a host and the sequencer.
//   master : host side   - offers jobs, consumes results
//   slave  : sequencer   - accepts jobs, presents held results
interface miner_job_sequencer_if
  import miner_pkg::*;
#(
  parameter int unsigned BYTES    = 12,
  parameter int unsigned TARGET_W = 8,
  parameter int unsigned NONCE_W  = 32
);

  logic                job_valid;
  logic                job_ready;
  logic [BYTES*8-1:0]  job_data;
  logic [TARGET_W-1:0] job_target;

  logic                res_valid;
  logic                res_ready;
  logic                res_found;
  logic [NONCE_W-1:0]  res_nonce;
  logic [ID_W-1:0]     res_job_id;

  modport master (
    output job_valid, job_data, job_target, res_ready,
    input  job_ready, res_valid, res_found, res_nonce, res_job_id
  );

  modport slave (
    input  job_valid, job_data, job_target, res_ready,
    output job_ready, res_valid, res_found, res_nonce, res_job_id
  );

endinterface

// File: rtl/miner_job_sequencer_fifo.sv
// Synchronous job FIFO with first-word fall-through read.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and data (ignored when full)
//   pop, dout  : read strobe and head-of-queue data (ignored when empty)
//   full/empty : occupancy flags
module miner_job_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the address bits match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop  && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/miner_job_sequencer.sv
// Queues header/target jobs and sequences each onto the miner core:
// load, hold miner_reset low, run under a watchdog, then hold the result.
//   clk, reset        : clock, asynchronous active-low reset
//   bus (slave)       : job accept handshake and held-result handshake
//   timeout_cycles    : run-cycle limit, 0 disables the watchdog
//   miner_*           : reset/header/target to the miner, finished/nonce back
//   busy, jobs_done   : activity flag and count of consumed results
module miner_job_sequencer
  import miner_pkg::*;
#(
  parameter int unsigned BYTES      = 12,
  parameter int unsigned TARGET_W   = 8,
  parameter int unsigned NONCE_W    = 32,
  parameter int unsigned JOB_DEPTH  = 4,
  parameter int unsigned TIMEOUT_W  = 20,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  miner_job_sequencer_if.slave  bus,
  input  logic [TIMEOUT_W-1:0]  timeout_cycles,
  output logic                  miner_reset,
  output logic [BYTES*8-1:0]    miner_data,
  output logic [TARGET_W-1:0]   miner_target,
  input  logic                  miner_finished,
  input  logic [NONCE_W-1:0]    miner_nonce,
  output logic                  busy,
  output logic [CNT_W-1:0]      jobs_done
);

  localparam int unsigned EW  = entry_width(BYTES, TARGET_W);
  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

  // Assertion is immediate; release is delayed through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic          push, pop, fifo_full, fifo_empty;
  logic [EW-1:0] fifo_din, fifo_dout;

  state_t               state_q, state_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [TIMEOUT_W-1:0] run_cnt_q, run_cnt_d;
  logic [ID_W-1:0]      id_cnt_q, id_cnt_d, cur_id_q, cur_id_d;
  logic                 mrst_q, mrst_d;
  logic [BYTES*8-1:0]   mdata_q, mdata_d;
  logic [TARGET_W-1:0]  mtarget_q, mtarget_d;
  logic                 res_valid_q, res_valid_d, res_found_q, res_found_d;
  logic [NONCE_W-1:0]   res_nonce_q, res_nonce_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic [CNT_W-1:0]     done_q, done_d;

  assign push     = bus.job_valid && !fifo_full;
  assign fifo_din = {bus.job_data, bus.job_target, id_cnt_q};

  miner_job_fifo #(
    .WIDTH (EW),
    .DEPTH (JOB_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    run_cnt_d   = run_cnt_q;
    id_cnt_d    = push ? id_cnt_q + 1'b1 : id_cnt_q;
    cur_id_d    = cur_id_q;
    mrst_d      = mrst_q;
    mdata_d     = mdata_q;
    mtarget_d   = mtarget_q;
    res_valid_d = res_valid_q;
    res_found_d = res_found_q;
    res_nonce_d = res_nonce_q;
    res_id_d    = res_id_q;
    done_d      = done_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          mdata_d   = fifo_dout[EW-1 -: BYTES*8];
          mtarget_d = fifo_dout[ID_W +: TARGET_W];
          cur_id_d  = fifo_dout[ID_W-1:0];
          mrst_d    = 1'b0;
          rst_cnt_d = RCW'(RST_CYCLES - 1);
          state_d   = RST;
        end
      end
      RST: begin
        if (rst_cnt_q == '0) begin
          mrst_d    = 1'b1;
          run_cnt_d = '0;
          state_d   = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (run_cnt_q != '1) run_cnt_d = run_cnt_q + 1'b1;
        // Finished takes priority over a watchdog expiry in the same cycle.
        if (miner_finished) begin
          res_found_d = 1'b1;
          res_nonce_d = miner_nonce;
          res_valid_d = 1'b1;
          res_id_d    = cur_id_q;
          state_d     = RES;
        end else if (timeout_cycles != '0 && run_cnt_q == timeout_cycles) begin
          res_found_d = 1'b0;
          res_nonce_d = '0;
          res_valid_d = 1'b1;
          res_id_d    = cur_id_q;
          state_d     = RES;
        end
      end
      RES: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          done_d      = done_q + 1'b1;
          mrst_d      = 1'b0;  // park the miner until the next job
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      run_cnt_q   <= '0;
      id_cnt_q    <= '0;
      cur_id_q    <= '0;
      mrst_q      <= 1'b0;
      mdata_q     <= '0;
      mtarget_q   <= '0;
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_nonce_q <= '0;
      res_id_q    <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      run_cnt_q   <= run_cnt_d;
      id_cnt_q    <= id_cnt_d;
      cur_id_q    <= cur_id_d;
      mrst_q      <= mrst_d;
      mdata_q     <= mdata_d;
      mtarget_q   <= mtarget_d;
      res_valid_q <= res_valid_d;
      res_found_q <= res_found_d;
      res_nonce_q <= res_nonce_d;
      res_id_q    <= res_id_d;
      done_q      <= done_d;
    end
  end

  assign bus.job_ready  = !fifo_full;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_found  = res_found_q;
  assign bus.res_nonce  = res_nonce_q;
  assign bus.res_job_id = res_id_q;
  assign miner_reset    = mrst_q;
  assign miner_data     = mdata_q;
  assign miner_target   = mtarget_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;
  assign jobs_done      = done_q;

endmodule

// File: tb/tb_miner_job_sequencer.sv
module tb_miner_job_sequencer;
  import miner_pkg::*;

  localparam int unsigned BYTES      = 12;
  localparam int unsigned TARGET_W   = 8;
  localparam int unsigned NONCE_W    = 32;
  localparam int unsigned JOB_DEPTH  = 4;
  localparam int unsigned TIMEOUT_W  = 20;
  localparam int unsigned RST_CYCLES = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [TIMEOUT_W-1:0] timeout_cycles;
  logic                 miner_reset;
  logic [BYTES*8-1:0]   miner_data;
  logic [TARGET_W-1:0]  miner_target;
  logic                 miner_finished;
  logic [NONCE_W-1:0]   miner_nonce;
  logic                 busy;
  logic [CNT_W-1:0]     jobs_done;

  miner_job_sequencer_if #(.BYTES(BYTES), .TARGET_W(TARGET_W), .NONCE_W(NONCE_W)) bus ();

  miner_job_sequencer #(
    .BYTES(BYTES), .TARGET_W(TARGET_W), .NONCE_W(NONCE_W),
    .JOB_DEPTH(JOB_DEPTH), .TIMEOUT_W(TIMEOUT_W), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .timeout_cycles (timeout_cycles),
    .miner_reset    (miner_reset),
    .miner_data     (miner_data),
    .miner_target   (miner_target),
    .miner_finished (miner_finished),
    .miner_nonce    (miner_nonce),
    .busy           (busy),
    .jobs_done      (jobs_done)
  );

  // Miner behaviour per job: finishes when sampled at edge (run start + fin); 0 = never.
  typedef struct {
    logic [BYTES*8-1:0]  data;
    logic [TARGET_W-1:0] target;
    int unsigned         fin;
    logic [NONCE_W-1:0]  nonce;
  } beh_t;
  typedef struct {
    logic [ID_W-1:0]    id;
    logic               found;
    logic [NONCE_W-1:0] nonce;
  } exp_t;

  beh_t            beh_q[$];
  exp_t            exp_q[$];
  int              checks = 0;
  int              failures = 0;
  logic [ID_W-1:0] next_id = '0;
  logic [15:0]     exp_done = '0;

  // Miner model: drives finished/nonce at negedges, checks the loaded job on each run start.
  initial begin : miner_model
    bit          prev;
    bit          have;
    int unsigned cyc;
    beh_t        b;
    prev = 0; have = 0; cyc = 0;
    miner_finished = 1'b0;
    miner_nonce = '0;
    forever begin
      @(negedge clk);
      if (miner_reset !== 1'b1) begin
        prev = 0; have = 0;
        miner_finished = 1'b0;
      end else begin
        if (!prev) begin
          prev = 1; cyc = 0;
          checks++;
          if (beh_q.size() == 0) begin
            failures++; have = 0;
            $display("FAIL run_start: miner released with no job pending");
          end else begin
            b = beh_q.pop_front(); have = 1;
            if ({miner_data, miner_target} !== {b.data, b.target}) begin
              failures++;
              $display("FAIL miner_load: got %h/%h required %h/%h",
                       miner_data, miner_target, b.data, b.target);
            end
          end
        end else begin
          cyc++;
        end
        if (have && b.fin != 0 && cyc + 1 >= b.fin) begin
          miner_finished = 1'b1;
          miner_nonce = b.nonce;
        end else begin
          miner_finished = 1'b0;
          miner_nonce = $urandom;
        end
      end
    end
  end

  // Result scoreboard: compares each consumed result, then jobs_done one cycle later.
  initial begin : consumer
    bit   pend;
    exp_t e;
    pend = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        pend = 0;
      end else begin
        if (pend) begin
          pend = 0;
          checks++;
          if (jobs_done !== exp_done) begin
            failures++;
            $display("FAIL jobs_done: got %0d required %0d", jobs_done, exp_done);
          end
        end
        if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL result: unexpected result id=%0d", bus.res_job_id);
          end else begin
            e = exp_q.pop_front();
            if ({bus.res_job_id, bus.res_found, bus.res_nonce} !== {e.id, e.found, e.nonce}) begin
              failures++;
              $display("FAIL result id/found/nonce: got %0d/%b/%h required %0d/%b/%h",
                       bus.res_job_id, bus.res_found, bus.res_nonce, e.id, e.found, e.nonce);
            end
            exp_done = exp_done + 16'd1;
            pend = 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_job(input logic [BYTES*8-1:0] data, input logic [TARGET_W-1:0] target,
                          input int unsigned fin, input logic [NONCE_W-1:0] nonce);
    bit   ok, rdy;
    beh_t b;
    exp_t e;
    ok = 0;
    bus.job_valid = 1'b1; bus.job_data = data; bus.job_target = target;
    for (int i = 0; i < 3000 && !ok; i++) begin
      rdy = bus.job_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1;
    end
    bus.job_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL push: job_ready stayed %b, required 1", bus.job_ready);
    end else begin
      b.data = data; b.target = target; b.fin = fin; b.nonce = nonce;
      beh_q.push_back(b);
      e.id = next_id;
      e.found = (fin != 0) && (timeout_cycles == 0 || fin <= int'(timeout_cycles) + 1);
      e.nonce = e.found ? nonce : '0;
      exp_q.push_back(e);
      next_id = next_id + 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      done = (exp_q.size() == 0) && (busy === 1'b0);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s idle: pending=%0d busy=%b required 0/0", name, exp_q.size(), busy);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; bus.job_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    beh_q.delete(); exp_q.delete();
    next_id = '0; exp_done = '0;
    reset = 1'b1;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({miner_reset, bus.res_valid, bus.res_found, busy, bus.job_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00001",
               {miner_reset, bus.res_valid, bus.res_found, busy, bus.job_ready});
    end
    checks++;
    if ({miner_data, miner_target, bus.res_nonce, bus.res_job_id, jobs_done} !== '0) begin
      failures++;
      $display("FAIL reset_values: got %h/%h/%h/%h/%h required all 0",
               miner_data, miner_target, bus.res_nonce, bus.res_job_id, jobs_done);
    end
    do_reset();
    checks++;
    if ({busy, bus.job_ready, miner_reset} !== 3'b010) begin
      failures++;
      $display("FAIL reset_release: busy/ready/mrst got %b required 010",
               {busy, bus.job_ready, miner_reset});
    end
  endtask

  task automatic test_single();
    logic [BYTES*8-1:0] hdr;
    int n;
    hdr = 96'h397d9f2f40ca9e6c6b1f3324;
    timeout_cycles = '0;
    push_job(hdr, 8'd150, 40, 32'h0000_1A2B);
    n = 0;
    while (miner_data !== hdr && n < 50) begin @(posedge clk); #1; n++; end
    n = 0;
    while (miner_reset !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != RST_CYCLES) begin
      failures++;
      $display("FAIL miner_reset_low: got %0d cycles required %0d", n, RST_CYCLES);
    end
    wait_idle("single");
    checks++;
    if ({bus.res_found, bus.res_nonce, bus.res_job_id, jobs_done} !== {1'b1, 32'h1A2B, 8'd0, 16'd1})
    begin
      failures++;
      $display("FAIL single: found/nonce/id/done got %b/%h/%0d/%0d required 1/1a2b/0/1",
               bus.res_found, bus.res_nonce, bus.res_job_id, jobs_done);
    end
  endtask

  task automatic test_timeout();
    int n;
    timeout_cycles = 20'd70;
    push_job(96'hdead_beef_0123_4567_89ab_cdef, 8'd7, 0, 32'h0);
    n = 0;
    while (miner_reset !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 71) begin
      failures++;
      $display("FAIL timeout_latency: got %0d edges required 71", n);
    end
    checks++;
    if ({bus.res_found, bus.res_nonce} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL timeout_result: found/nonce got %b/%h required 0/0",
               bus.res_found, bus.res_nonce);
    end
    wait_idle("timeout");
  endtask

  task automatic test_queue_full();
    int n;
    do_reset();
    timeout_cycles = '0;
    push_job(96'h1, 8'd10, 60, 32'hA000_0000);
    n = 0;
    while (miner_reset !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    for (int j = 1; j <= 4; j++) push_job(96'(j + 16), 8'(j), 3, 32'hA000_0000 + 32'(j));
    checks++;
    if ({bus.job_ready, busy} !== 2'b01) begin
      failures++;
      $display("FAIL queue_full: ready/busy got %b/%b required 0/1", bus.job_ready, busy);
    end
    wait_idle("queue_full");
    checks++;
    if ({bus.job_ready, jobs_done} !== {1'b1, 16'd5}) begin
      failures++;
      $display("FAIL queue_drain: ready/done got %b/%0d required 1/5", bus.job_ready, jobs_done);
    end
  endtask

  task automatic test_backpressure();
    logic [ID_W+NONCE_W+1:0] snap;
    logic [BYTES*8-1:0]      hdr;
    int n;
    hdr = 96'hcafe_0000_1111_2222_3333_4444;
    timeout_cycles = '0;
    bus.res_ready = 1'b0;
    push_job(hdr, 8'd33, 5, 32'h5555_0001);
    push_job(96'h77, 8'd34, 7, 32'h5555_0002);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    snap = {bus.res_valid, bus.res_found, bus.res_nonce, bus.res_job_id};
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.res_valid, bus.res_found, bus.res_nonce, bus.res_job_id, miner_data, miner_reset}
          !== {snap, hdr, 1'b1}) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: res=%h data=%h mrst=%b required %h/%h/1",
                 k, {bus.res_valid, bus.res_found, bus.res_nonce, bus.res_job_id},
                 miner_data, miner_reset, snap, hdr);
      end
    end
    bus.res_ready = 1'b1;
    wait_idle("backpressure");
  endtask

  task automatic test_simultaneous();
    int n;
    timeout_cycles = 20'd20;
    push_job(96'h5151, 8'd1, 21, 32'h0BAD_F00D);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if ({bus.res_found, bus.res_nonce} !== {1'b1, 32'h0BAD_F00D}) begin
      failures++;
      $display("FAIL simultaneous: found/nonce got %b/%h required 1/0badf00d",
               bus.res_found, bus.res_nonce);
    end
    wait_idle("simultaneous");
    push_job(96'h5252, 8'd2, 22, 32'h1234_5678);
    push_job(96'h5353, 8'd3, 20, 32'h8765_4321);
    wait_idle("near_timeout");
  endtask

  task automatic test_reset_mid_run();
    int n;
    timeout_cycles = '0;
    for (int j = 0; j < 3; j++) push_job(96'(j + 100), 8'(j), 0, 32'h0);
    n = 0;
    while (miner_reset !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    reset = 1'b0;
    #1;
    checks++;
    if ({miner_reset, bus.res_valid, bus.res_found, busy, bus.job_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL midrun_flags: got %b required 00001",
               {miner_reset, bus.res_valid, bus.res_found, busy, bus.job_ready});
    end
    checks++;
    if ({miner_data, miner_target, bus.res_nonce, bus.res_job_id, jobs_done} !== '0) begin
      failures++;
      $display("FAIL midrun_values: got %h/%h/%h/%h/%h required all 0",
               miner_data, miner_target, bus.res_nonce, bus.res_job_id, jobs_done);
    end
    do_reset();
    checks++;
    if ({busy, bus.job_ready} !== 2'b01) begin
      failures++;
      $display("FAIL midrun_release: busy/ready got %b required 01", {busy, bus.job_ready});
    end
    push_job(96'h9999, 8'd9, 4, 32'h4444_4444);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.res_job_id !== 8'd0) begin
      failures++;
      $display("FAIL midrun_id_restart: got %0d required 0", bus.res_job_id);
    end
    wait_idle("midrun");
  endtask

  initial begin
    bus.job_valid = 1'b0;
    bus.job_data = '0;
    bus.job_target = '0;
    bus.res_ready = 1'b1;
    timeout_cycles = '0;
    test_reset();
    test_single();
    test_timeout();
    test_queue_full();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
